// File: rtl/mag_compare_sequencer.sv
// Multi-byte magnitude comparator that walks operands MSB-first through a shared
// external 8-bit comparator, stopping at the first differing byte.
module mag_compare_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic [7:0]            cmp_p,
    output logic [7:0]            cmp_q,
    output logic                  cmp_g_n,
    input  logic                  cmp_eq_n,
    input  logic                  cmp_gt_n,
    output logic                  busy,
    output logic                  done,
    output logic                  a_eq_b,
    output logic                  a_gt_b,
    output logic                  a_lt_b,
    output logic [3:0]            ncmp
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [2:0] MSB_IDX = 3'(NBYTES - 1);

    state_t                    state;
    state_t                    state_next;
    logic [NBYTES-1:0][7:0]    a_q;
    logic [NBYTES-1:0][7:0]    b_q;
    logic                      signed_q;
    logic [2:0]                idx;
    logic                      accept;
    logic [7:0]                p_byte;
    logic [7:0]                q_byte;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = COMPARE;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            COMPARE: begin
                if (cmp_eq_n || (idx == 3'd0)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte select; in signed mode the MSB sign bits are flipped so an unsigned
    // byte compare orders two's-complement values correctly.
    always_comb begin
        p_byte = 8'h00;
        q_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == 3'(i)) begin
                p_byte = a_q[i];
                q_byte = b_q[i];
            end
        end
        if (signed_q && (idx == MSB_IDX)) begin
            p_byte[7] = ~p_byte[7];
            q_byte[7] = ~q_byte[7];
        end
    end

    assign busy    = (state == COMPARE);
    assign done    = (state == DONE);
    assign cmp_g_n = ~busy;
    assign cmp_p   = busy ? p_byte : 8'h00;
    assign cmp_q   = busy ? q_byte : 8'h00;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx      <= 3'd0;
            a_eq_b   <= 1'b0;
            a_gt_b   <= 1'b0;
            a_lt_b   <= 1'b0;
            ncmp     <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                signed_q <= signed_mode;
                idx      <= MSB_IDX;
                a_eq_b   <= 1'b0;
                a_gt_b   <= 1'b0;
                a_lt_b   <= 1'b0;
                ncmp     <= 4'd0;
            end else if (state == COMPARE) begin
                ncmp <= ncmp + 4'd1;
                // eq_n has priority, so an illegal both-low response reads as equal
                if (cmp_eq_n) begin
                    a_gt_b <= ~cmp_gt_n;
                    a_lt_b <= cmp_gt_n;
                end else if (idx != 3'd0) begin
                    idx <= idx - 3'd1;
                end else begin
                    a_eq_b <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mag_compare_sequencer.sv
// Directed self-checking bench for mag_compare_sequencer with a behavioural
// model of the shared 8-bit comparator.
module tb_mag_compare_sequencer;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  cmp_p;
    logic [7:0]  cmp_q;
    logic        cmp_g_n;
    logic        cmp_eq_n;
    logic        cmp_gt_n;
    logic        busy;
    logic        done;
    logic        a_eq_b;
    logic        a_gt_b;
    logic        a_lt_b;
    logic [3:0]  ncmp;

    int          check_count = 0;
    int          error_count = 0;
    logic [7:0]  p_seq [0:7];
    int          n_busy;
    int          cycles;
    logic        saw_done;

    mag_compare_sequencer #(.NBYTES(4)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .cmp_p       (cmp_p),
        .cmp_q       (cmp_q),
        .cmp_g_n     (cmp_g_n),
        .cmp_eq_n    (cmp_eq_n),
        .cmp_gt_n    (cmp_gt_n),
        .busy        (busy),
        .done        (done),
        .a_eq_b      (a_eq_b),
        .a_gt_b      (a_gt_b),
        .a_lt_b      (a_lt_b),
        .ncmp        (ncmp)
    );

    // Shared comparator: outputs inactive (high) while disabled
    assign cmp_eq_n = cmp_g_n ? 1'b1 : (cmp_p != cmp_q);
    assign cmp_gt_n = cmp_g_n ? 1'b1 : !(cmp_p > cmp_q);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Presents one start for exactly one rising edge; returns 1 time unit after it
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sm);
        a           = av;
        b           = bv;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    task automatic run_compare(input string tag, input logic [31:0] av, input logic [31:0] bv,
                               input logic sm, input logic [2:0] exp_flags, input logic [3:0] exp_n);
        applyStimulus(av, bv, sm);
        n_busy = 0;
        cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) begin
                if (n_busy < 8) p_seq[n_busy] = cmp_p;
                n_busy++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_latency"}, cycles, {28'd0, exp_n});
        checkOutput({tag, "_busy_cycles"}, n_busy, {28'd0, exp_n});
        checkOutput({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_flags"}, {29'd0, a_eq_b, a_gt_b, a_lt_b}, {29'd0, exp_flags});
        checkOutput({tag, "_ncmp"}, {28'd0, ncmp}, {28'd0, exp_n});
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_hold"}, {25'd0, a_eq_b, a_gt_b, a_lt_b, ncmp}, {25'd0, exp_flags, exp_n});
    endtask

    initial begin
        clr_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = 32'd0;
        b           = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
        checkOutput("rst_flags_ncmp", {25'd0, a_eq_b, a_gt_b, a_lt_b, ncmp}, 32'd0);
        checkOutput("rst_cmp_bus", {15'd0, cmp_g_n, cmp_p, cmp_q}, {15'd0, 1'b1, 16'h0000});
        #2 clr_n = 1'b1;
        @(posedge clk);
        #1;

        run_compare("eq", 32'h12345678, 32'h12345678, 1'b0, 3'b100, 4'd4);
        checkOutput("eq_seq0", {24'd0, p_seq[0]}, 32'h12);
        checkOutput("eq_seq1", {24'd0, p_seq[1]}, 32'h34);
        checkOutput("eq_seq2", {24'd0, p_seq[2]}, 32'h56);
        checkOutput("eq_seq3", {24'd0, p_seq[3]}, 32'h78);
        checkOutput("idle_cmp_bus", {15'd0, cmp_g_n, cmp_p, cmp_q}, {15'd0, 1'b1, 16'h0000});

        run_compare("gt_msb", 32'hFF000000, 32'h00FFFFFF, 1'b0, 3'b010, 4'd1);
        run_compare("lt_lsb", 32'h0000003C, 32'h0000003D, 1'b0, 3'b001, 4'd4);
        run_compare("signed_neg", 32'h80000000, 32'h00000001, 1'b1, 3'b001, 4'd1);
        checkOutput("signed_msb_p", {24'd0, p_seq[0]}, 32'h00);
        run_compare("unsigned_big", 32'h80000000, 32'h00000001, 1'b0, 3'b010, 4'd1);
        run_compare("signed_m2_m1", 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b001, 4'd4);
        run_compare("signed_pos_gt", 32'h00000100, 32'hFFFFFF00, 1'b1, 3'b010, 4'd1);

        // start held through COMPARE with new operands, then re-accepted in DONE
        a           = 32'h12345678;
        b           = 32'h12345678;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        a      = 32'h00000000;
        b      = 32'hFFFFFFFF;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("hold_done", {31'd0, done}, 32'd1);
        checkOutput("hold_latency", cycles, 32'd4);
        checkOutput("hold_result", {25'd0, a_eq_b, a_gt_b, a_lt_b, ncmp}, {25'd0, 3'b100, 4'd4});
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy", {30'd0, busy, done}, 32'b10);
        checkOutput("b2b_cleared", {25'd0, a_eq_b, a_gt_b, a_lt_b, ncmp}, 32'd0);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("b2b_latency", cycles, 32'd1);
        checkOutput("b2b_result", {25'd0, a_eq_b, a_gt_b, a_lt_b, ncmp}, {25'd0, 3'b001, 4'd1});
        @(posedge clk);
        #1;

        // Asynchronous clear in the second COMPARE cycle
        applyStimulus(32'h12345678, 32'h12345678, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("abort_pre_ncmp", {28'd0, ncmp}, 32'd1);
        #2 clr_n = 1'b0;
        #1;
        checkOutput("abort_busy_done", {30'd0, busy, done}, 32'd0);
        checkOutput("abort_flags_ncmp", {25'd0, a_eq_b, a_gt_b, a_lt_b, ncmp}, 32'd0);
        checkOutput("abort_cmp_bus", {15'd0, cmp_g_n, cmp_p, cmp_q}, {15'd0, 1'b1, 16'h0000});
        #1 clr_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_compare("after_abort", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 3'b100, 4'd4);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mag_compare_sequencer.md
MAG_COMPARE_SEQUENCER -- requirements
Module: mag_compare_sequencer

Interface
REQ-001 Parameter NBYTES, default 4, operand width in bytes; legal range 2..8.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a comparison; sampled on rising clk.
REQ-005 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 a  input  8*NBYTES  operand A; captured with start.
REQ-007 b  input  8*NBYTES  operand B; captured with start.
REQ-008 cmp_p  output  8  byte driven to P inputs of the shared 8-bit comparator.
REQ-009 cmp_q  output  8  byte driven to Q inputs of the shared 8-bit comparator.
REQ-010 cmp_g_n  output  1  comparator enable, active-low.
REQ-011 cmp_eq_n  input  1  comparator P=Q result, active-low, combinational from cmp_p/cmp_q/cmp_g_n.
REQ-012 cmp_gt_n  input  1  comparator P>Q result, active-low, combinational.
REQ-013 busy  output  1  high while a comparison is in progress.
REQ-014 done  output  1  one-cycle pulse when results become valid.
REQ-015 a_eq_b / a_gt_b / a_lt_b  output  1 each  registered result flags, one-hot when valid.
REQ-016 ncmp  output  4  number of comparator cycles used by the last comparison.

Function
REQ-017 FSM states: IDLE, COMPARE, DONE.
REQ-018 IDLE or DONE with start=1 at an edge: capture a, b, signed_mode; byte index := NBYTES-1; next state COMPARE; result flags cleared to 0; ncmp := 0.
REQ-019 start is ignored while in COMPARE (busy=1); captured operands are unaffected.
REQ-020 In COMPARE: cmp_g_n=0; cmp_p = byte[index] of captured A, cmp_q = byte[index] of captured B; index NBYTES-1 is the most significant byte.
REQ-021 signed_mode=1: bit 7 of the most significant byte of both A and B is inverted before driving cmp_p/cmp_q; other bytes unchanged.
REQ-022 Each COMPARE edge increments ncmp and samples cmp_eq_n/cmp_gt_n.
REQ-023 cmp_eq_n=1 (bytes differ): a_gt_b := ~cmp_gt_n, a_lt_b := cmp_gt_n; next state DONE (early termination).
REQ-024 cmp_eq_n=0 and index>0: index decrements; stay in COMPARE.
REQ-025 cmp_eq_n=0 and index=0: a_eq_b := 1; next state DONE.
REQ-026 Latency: start at edge 0 -> k comparator cycles (1 <= k <= NBYTES) -> done=1 in the cycle following edge k.
REQ-027 DONE lasts exactly one cycle, done=1 and busy=0; without start the next state is IDLE; with start, proceed per REQ-018 (back-to-back operation, no idle gap).
REQ-028 Outside COMPARE: cmp_g_n=1, cmp_p=8'h00, cmp_q=8'h00.
REQ-029 busy=1 exactly in COMPARE; done=1 exactly in DONE.
REQ-030 Result flags and ncmp hold their value through IDLE until the next accepted start.
REQ-031 If both comparator outputs are low (illegal), cmp_eq_n takes precedence: treated as equal.

Reset
REQ-032 clr_n=0 forces immediately, regardless of clk: state IDLE, busy=0, done=0, a_eq_b=a_gt_b=a_lt_b=0, ncmp=0, cmp_g_n=1, cmp_p=cmp_q=0, captured operands and index cleared.
REQ-033 Reset during COMPARE aborts the comparison; no done pulse is produced for it.
REQ-034 First start is accepted on the first rising edge at which clr_n=1.

Verification (NBYTES=4, bench instantiates the 8-bit comparator model as the shared resource)
REQ-035 a=b=32'h12345678, unsigned -> 4 COMPARE cycles, cmp_p sequence 12,34,56,78; done in cycle 5; a_eq_b=1, ncmp=4.
REQ-036 a=32'hFF000000, b=32'h00FFFFFF, unsigned -> 1 COMPARE cycle, done in cycle 2; a_gt_b=1, ncmp=1.
REQ-037 a=32'h0000003C, b=32'h0000003D, unsigned -> 4 COMPARE cycles; a_lt_b=1, ncmp=4.
REQ-038 a=32'h80000000, b=32'h00000001: signed_mode=1 -> a_lt_b=1, ncmp=1; repeated with signed_mode=0 -> a_gt_b=1, ncmp=1.
REQ-039 start held high during COMPARE with a/b changed -> results match the originally captured operands; a second start in the DONE cycle starts a new comparison on the next cycle.
REQ-040 clr_n pulsed low in cycle 2 of a 4-byte equal compare -> all outputs at reset values asynchronously, no done pulse; the next start completes normally.
